// File: rtl/memory_cycle_lsu.sv
// Memory-stage load/store unit: aligns and strobes byte/half/word accesses on a
// valid/ready data port, stalls upstream until each access completes, and owns the M->W register.
//
// state  | meaning
// S_IDLE | presenting the current M-stage access (if any) to memory
// S_WAIT | load accepted, waiting for the response data
module memory_cycle_lsu #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5,
  parameter int STRB_W    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 RegWriteM,
  input  logic                 MemWriteM,
  input  logic [1:0]           ResultSrcM,
  input  logic [2:0]           Funct3M,
  input  logic [REG_IDX_W-1:0] RD_M,
  input  logic [XLEN-1:0]      PCPlus4M,
  input  logic [XLEN-1:0]      WriteDataM,
  input  logic [XLEN-1:0]      ALU_ResultM,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  output logic [STRB_W-1:0]    dmem_wstrb,
  input  logic                 dmem_rsp_valid,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 StallM,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic [REG_IDX_W-1:0] RD_W,
  output logic [XLEN-1:0]      PCPlus4W,
  output logic [XLEN-1:0]      ALU_ResultW,
  output logic [XLEN-1:0]      ReadDataW,
  output logic                 MisalignW
);

  typedef enum logic {S_IDLE, S_WAIT} stateT;

  stateT       state, nextState;
  logic [1:0]  laneQ;
  logic        isLoad, isStore, isOp, isHalf, isWord;
  logic        misalign, alignedOp, done, handshake;
  logic [7:0]  byteVal;
  logic [15:0] halfVal;
  logic [XLEN-1:0] loadData;

  assign isLoad    = (ResultSrcM == 2'b01);
  assign isStore   = MemWriteM;
  assign isOp      = isLoad | isStore;
  assign isHalf    = (Funct3M[1:0] == 2'b01);
  assign isWord    = (Funct3M[1:0] == 2'b10);
  assign misalign  = isOp & ((isHalf & ALU_ResultM[0]) | (isWord & (ALU_ResultM[1:0] != 2'b00)));
  assign alignedOp = isOp & ~misalign;
  assign handshake = dmem_req_valid & dmem_req_ready;

  always_comb begin
    nextState      = state;
    dmem_req_valid = 1'b0;
    done           = 1'b0;
    case (state)
      S_IDLE: begin
        dmem_req_valid = alignedOp;
        if (alignedOp && dmem_req_ready) begin
          if (isLoad) nextState = S_WAIT;
          else        done      = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_rsp_valid) begin
          done      = 1'b1;
          nextState = S_IDLE;
        end
      end
      default: nextState = S_IDLE;
    endcase
  end

  assign StallM    = alignedOp & ~done;
  assign dmem_we   = isStore;
  assign dmem_addr = {ALU_ResultM[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_wstrb = '0;
    dmem_wdata = WriteDataM;
    if (isStore) begin
      case (Funct3M[1:0])
        2'b00: begin
          dmem_wstrb = 4'b0001 << ALU_ResultM[1:0];
          dmem_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          dmem_wstrb = 4'b0011 << {ALU_ResultM[1], 1'b0};
          dmem_wdata = {2{WriteDataM[15:0]}};
        end
        default: dmem_wstrb = 4'b1111;
      endcase
    end
  end

  // Lane comes from the latched accept address; the width/sign come from the held M inputs.
  always_comb begin
    case (laneQ)
      2'd0:    byteVal = dmem_rdata[7:0];
      2'd1:    byteVal = dmem_rdata[15:8];
      2'd2:    byteVal = dmem_rdata[23:16];
      default: byteVal = dmem_rdata[31:24];
    endcase
    halfVal = laneQ[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (Funct3M)
      3'b000:  loadData = {{24{byteVal[7]}}, byteVal};
      3'b100:  loadData = {24'b0, byteVal};
      3'b001:  loadData = {{16{halfVal[15]}}, halfVal};
      3'b101:  loadData = {16'b0, halfVal};
      default: loadData = dmem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      laneQ       <= 2'b00;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      MisalignW   <= 1'b0;
    end else begin
      state <= nextState;
      if (state == S_IDLE && handshake && isLoad) laneQ <= ALU_ResultM[1:0];
      if (StallM) begin
        RegWriteW  <= 1'b0;
        ResultSrcW <= 2'b00;
        MisalignW  <= 1'b0;
      end else begin
        RegWriteW   <= RegWriteM & ~misalign;
        ResultSrcW  <= ResultSrcM;
        RD_W        <= RD_M;
        PCPlus4W    <= PCPlus4M;
        ALU_ResultW <= ALU_ResultM;
        // Only a completed load may put data on the W bus; anything else writes zero.
        ReadDataW   <= (isLoad && !misalign) ? loadData : '0;
        MisalignW   <= misalign;
      end
    end
  end

endmodule

// File: tb/tb_memory_cycle_lsu.sv
// Directed bench for memory_cycle_lsu: ALU pass-through, stores, loads with
// extension, misalignment and reset during an outstanding load.
module tb_memory_cycle_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        StallM, RegWriteW, MisalignW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  int checks = 0;
  int errors = 0;

  memory_cycle_lsu dut (
    .clock(clock), .reset(reset),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .MisalignW(MisalignW)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic setOp(input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] wd, input logic [31:0] addr);
    RegWriteM   = rw;
    MemWriteM   = mw;
    ResultSrcM  = rs;
    Funct3M     = f3;
    RD_M        = rd;
    PCPlus4M    = 32'h0000_0044;
    WriteDataM  = wd;
    ALU_ResultM = addr;
  endtask

  task automatic idleInputs();
    setOp(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);
    PCPlus4M       = 32'h0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = 32'h0;
  endtask

  task automatic test_reset();
    idleInputs();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (StallM !== 1'b0 || dmem_req_valid !== 1'b0 || MisalignW !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: stall=%b valid=%b misalign=%b, want 0 0 0", StallM, dmem_req_valid, MisalignW);
    end
    checks++;
    if (RegWriteW !== 1'b0 || ReadDataW !== 32'h0 || ALU_ResultW !== 32'h0 || RD_W !== 5'd0) begin
      errors++;
      $display("FAIL reset_w: regwrite=%b rdata=%h alu=%h rd=%0d, want all 0", RegWriteW, ReadDataW, ALU_ResultW, RD_W);
    end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    setOp(1'b1, 1'b0, 2'b00, 3'b000, 5'd5, 32'h0, 32'h0000_1234);
    #1;
    checks++;
    if (StallM !== 1'b0 || dmem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL alu_noreq: stall=%b valid=%b, want 0 0", StallM, dmem_req_valid);
    end
    step();
    idleInputs();
    checks++;
    if (RegWriteW !== 1'b1 || RD_W !== 5'd5 || ALU_ResultW !== 32'h1234 || PCPlus4W !== 32'h44) begin
      errors++;
      $display("FAIL alu_w: regwrite=%b rd=%0d alu=%h pc4=%h, want 1 5 00001234 00000044", RegWriteW, RD_W, ALU_ResultW, PCPlus4W);
    end
  endtask

  task automatic test_store();
    setOp(1'b0, 1'b1, 2'b00, 3'b010, 5'd0, 32'hDEAD_BEEF, 32'h0000_0100);
    dmem_req_ready = 1'b1;
    #1;
    checks++;
    if (dmem_req_valid !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h100 ||
        dmem_wstrb !== 4'b1111 || dmem_wdata !== 32'hDEAD_BEEF || StallM !== 1'b0) begin
      errors++;
      $display("FAIL sw_req: valid=%b we=%b addr=%h strb=%b wdata=%h stall=%b, want 1 1 00000100 1111 deadbeef 0",
               dmem_req_valid, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, StallM);
    end
    step();
    // sb at lane 1 with memory initially not ready: stalls, then completes with no stall
    setOp(1'b0, 1'b1, 2'b00, 3'b000, 5'd0, 32'h1234_5678, 32'h0000_0101);
    dmem_req_ready = 1'b0;
    #1;
    checks++;
    if (StallM !== 1'b1 || dmem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL sb_notready: stall=%b valid=%b, want 1 1", StallM, dmem_req_valid);
    end
    step();
    dmem_req_ready = 1'b1;
    #1;
    checks++;
    if (StallM !== 1'b0 || dmem_wstrb !== 4'b0010 || dmem_wdata !== 32'h7878_7878 || dmem_addr !== 32'h100) begin
      errors++;
      $display("FAIL sb_lane: stall=%b strb=%b wdata=%h addr=%h, want 0 0010 78787878 00000100",
               StallM, dmem_wstrb, dmem_wdata, dmem_addr);
    end
    step();
    idleInputs();
  endtask

  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] expData);
    int stallCount = 0;
    setOp(1'b1, 1'b0, 2'b01, f3, 5'd7, 32'h0, 32'h0000_0103);
    for (int i = 0; i < 4; i++) begin
      dmem_req_ready = (i == 2);
      dmem_rsp_valid = (i == 3);
      dmem_rdata     = (i == 3) ? 32'h80FF_FFFF : 32'h0;
      #1;
      if (StallM === 1'b1) stallCount++;
      if (i == 1) begin
        checks++;
        if (RegWriteW !== 1'b0 || dmem_req_valid !== 1'b1 || dmem_wstrb !== 4'b0000) begin
          errors++;
          $display("FAIL lb_bubble: regwrite=%b valid=%b strb=%b, want 0 1 0000", RegWriteW, dmem_req_valid, dmem_wstrb);
        end
      end
      if (i == 3) begin
        checks++;
        if (dmem_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL lb_waitreq: valid=%b, want 0", dmem_req_valid);
        end
      end
      step();
    end
    idleInputs();
    checks++;
    if (stallCount != 3) begin
      errors++;
      $display("FAIL lb_stalls f3=%b: got %0d stall cycles, want 3", f3, stallCount);
    end
    checks++;
    if (ReadDataW !== expData || RegWriteW !== 1'b1 || RD_W !== 5'd7 || ResultSrcW !== 2'b01) begin
      errors++;
      $display("FAIL lb_data f3=%b: rdata=%h regwrite=%b rd=%0d src=%b, want %h 1 7 01",
               f3, ReadDataW, RegWriteW, RD_W, ResultSrcW, expData);
    end
  endtask

  task automatic test_half();
    setOp(1'b0, 1'b1, 2'b00, 3'b001, 5'd0, 32'h0000_ABCD, 32'h0000_0202);
    dmem_req_ready = 1'b1;
    #1;
    checks++;
    if (dmem_wstrb !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD || dmem_addr !== 32'h200 || StallM !== 1'b0) begin
      errors++;
      $display("FAIL sh_lane: strb=%b wdata=%h addr=%h stall=%b, want 1100 abcdabcd 00000200 0",
               dmem_wstrb, dmem_wdata, dmem_addr, StallM);
    end
    step();
    setOp(1'b1, 1'b0, 2'b01, 3'b101, 5'd9, 32'h0, 32'h0000_0202);
    #1;
    checks++;
    if (StallM !== 1'b1 || dmem_we !== 1'b0 || dmem_wstrb !== 4'b0000) begin
      errors++;
      $display("FAIL lhu_accept: stall=%b we=%b strb=%b, want 1 0 0000", StallM, dmem_we, dmem_wstrb);
    end
    step();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 32'hABCD_0000;
    #1;
    checks++;
    if (StallM !== 1'b0) begin
      errors++;
      $display("FAIL lhu_rsp_stall: stall=%b, want 0", StallM);
    end
    step();
    idleInputs();
    checks++;
    if (ReadDataW !== 32'h0000_ABCD || RD_W !== 5'd9) begin
      errors++;
      $display("FAIL lhu_data: rdata=%h rd=%0d, want 0000abcd 9", ReadDataW, RD_W);
    end
    // signed half in the low lane
    setOp(1'b1, 1'b0, 2'b01, 3'b001, 5'd10, 32'h0, 32'h0000_0200);
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 32'h1234_F00F;
    step();
    idleInputs();
    checks++;
    if (ReadDataW !== 32'hFFFF_F00F) begin
      errors++;
      $display("FAIL lh_sign: rdata=%h, want fffff00f", ReadDataW);
    end
  endtask

  task automatic test_misalign();
    setOp(1'b1, 1'b0, 2'b01, 3'b010, 5'd3, 32'h0, 32'h0000_0101);
    dmem_req_ready = 1'b1;
    #1;
    checks++;
    if (dmem_req_valid !== 1'b0 || StallM !== 1'b0) begin
      errors++;
      $display("FAIL lw_mis_req: valid=%b stall=%b, want 0 0", dmem_req_valid, StallM);
    end
    step();
    idleInputs();
    checks++;
    if (MisalignW !== 1'b1 || RegWriteW !== 1'b0) begin
      errors++;
      $display("FAIL lw_mis_w: misalign=%b regwrite=%b, want 1 0", MisalignW, RegWriteW);
    end
    step();
    checks++;
    if (MisalignW !== 1'b0) begin
      errors++;
      $display("FAIL mis_pulse: misalign=%b, want 0", MisalignW);
    end
  endtask

  task automatic test_reset_wait();
    setOp(1'b1, 1'b0, 2'b01, 3'b010, 5'd12, 32'h0, 32'h0000_0300);
    dmem_req_ready = 1'b1;
    step();
    idleInputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 32'hCAFE_F00D;
    #1;
    checks++;
    if (dmem_req_valid !== 1'b0 || StallM !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_ctrl: valid=%b stall=%b, want 0 0", dmem_req_valid, StallM);
    end
    step();
    dmem_rsp_valid = 1'b0;
    checks++;
    if (RegWriteW !== 1'b0 || ReadDataW !== 32'h0 || MisalignW !== 1'b0 || ALU_ResultW !== 32'h0) begin
      errors++;
      $display("FAIL rstwait_w: regwrite=%b rdata=%h misalign=%b alu=%h, want 0 0 0 0",
               RegWriteW, ReadDataW, MisalignW, ALU_ResultW);
    end
    step();
    checks++;
    if (RegWriteW !== 1'b0 || ReadDataW !== 32'h0 || StallM !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_hold: regwrite=%b rdata=%h stall=%b, want 0 0 0", RegWriteW, ReadDataW, StallM);
    end
  endtask

  initial begin
    reset = 1'b1;
    idleInputs();
    @(negedge clock);
    test_reset();
    step();
    test_alu();
    test_store();
    test_load_byte(3'b000, 32'hFFFF_FF80);
    test_load_byte(3'b100, 32'h0000_0080);
    test_half();
    test_misalign();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
